// File: rtl/elevator_pkg.sv
// Shared types and default timing constants for the elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMoveUp,
    StMoveDown,
    StDoorOpen
  } state_e;

  typedef enum logic {
    DirUp,
    DirDown
  } dir_e;

  localparam int unsigned DefNumFloors  = 4;
  localparam int unsigned DefFloorTicks = 4;
  localparam int unsigned DefDoorTicks  = 3;

endpackage

// File: rtl/elevator_req_scan.sv
// Classifies outstanding calls relative to the car: any above, any below, one at this floor.
module elevator_req_scan #(
  parameter int unsigned NUM_FLOORS = 4,
  localparam int unsigned FW = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] merged_i,
  input  logic [FW-1:0]         floor_i,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  here_o
);

  always_comb begin
    above_o = 1'b0;
    below_o = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (i > 32'(floor_i)) above_o = above_o | merged_i[i];
      if (i < 32'(floor_i)) below_o = below_o | merged_i[i];
    end
    here_o = merged_i[floor_i];
  end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN-policy elevator sequencer: owns car position, latched calls, travel and door timing.
module elevator_ctrl import elevator_pkg::*; #(
  parameter int unsigned NUM_FLOORS  = DefNumFloors,
  parameter int unsigned FLOOR_TICKS = DefFloorTicks,
  parameter int unsigned DOOR_TICKS  = DefDoorTicks,
  localparam int unsigned FW = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FW-1:0]         floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  arrive
);

  localparam int unsigned TW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam int unsigned DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [TW-1:0] TravelLast = TW'(FLOOR_TICKS - 1);
  localparam logic [DW-1:0] DoorLast   = DW'(DOOR_TICKS - 1);

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d;
  logic [FW-1:0]         floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TW-1:0]         travel_q, travel_d;
  logic [DW-1:0]         door_q, door_d;
  logic                  arrive_q, arrive_d;
  logic                  moving_up_q, moving_down_q, door_open_q;

  logic [NUM_FLOORS-1:0] merged;
  logic                  above, below, here;
  logic [FW-1:0]         floor_up, floor_dn;

  assign merged   = pending_q | req;
  assign floor_up = floor_q + FW'(1);
  assign floor_dn = floor_q - FW'(1);

  elevator_req_scan #(
    .NUM_FLOORS(NUM_FLOORS)
  ) u_scan (
    .merged_i(merged),
    .floor_i (floor_q),
    .above_o (above),
    .below_o (below),
    .here_o  (here)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    floor_d   = floor_q;
    pending_d = merged;
    travel_d  = travel_q;
    door_d    = door_q;
    arrive_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (here) begin
          state_d            = StDoorOpen;
          pending_d[floor_q] = 1'b0;
          door_d             = '0;
          arrive_d           = 1'b1;
        end else if (above && below) begin
          state_d  = (dir_q == DirUp) ? StMoveUp : StMoveDown;
          travel_d = '0;
        end else if (above) begin
          state_d  = StMoveUp;
          dir_d    = DirUp;
          travel_d = '0;
        end else if (below) begin
          state_d  = StMoveDown;
          dir_d    = DirDown;
          travel_d = '0;
        end
      end
      StMoveUp, StMoveDown: begin
        if (travel_q == TravelLast) begin
          floor_d  = (state_q == StMoveUp) ? floor_up : floor_dn;
          travel_d = '0;
          if (merged[floor_d]) begin
            state_d            = StDoorOpen;
            pending_d[floor_d] = 1'b0;
            door_d             = '0;
            arrive_d           = 1'b1;
          end
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end
      StDoorOpen: begin
        // A call at the open floor is absorbed and restarts the dwell.
        pending_d[floor_q] = 1'b0;
        if (here) begin
          door_d = '0;
        end else if (door_q == DoorLast) begin
          travel_d = '0;
          if (dir_q == DirUp && above) begin
            state_d = StMoveUp;
          end else if (dir_q == DirDown && below) begin
            state_d = StMoveDown;
          end else if (above) begin
            state_d = StMoveUp;
            dir_d   = DirUp;
          end else if (below) begin
            state_d = StMoveDown;
            dir_d   = DirDown;
          end else begin
            state_d = StIdle;
          end
        end else begin
          door_d = door_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      dir_q         <= DirUp;
      floor_q       <= '0;
      pending_q     <= '0;
      travel_q      <= '0;
      door_q        <= '0;
      arrive_q      <= 1'b0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_open_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      floor_q       <= floor_d;
      pending_q     <= pending_d;
      travel_q      <= travel_d;
      door_q        <= door_d;
      arrive_q      <= arrive_d;
      moving_up_q   <= (state_d == StMoveUp);
      moving_down_q <= (state_d == StMoveDown);
      door_open_q   <= (state_d == StDoorOpen);
    end
  end

  assign floor       = floor_q;
  assign pending     = pending_q;
  assign arrive      = arrive_q;
  assign moving_up   = moving_up_q;
  assign moving_down = moving_down_q;
  assign door_open   = door_open_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed vector table, corner-case sequences, random calls vs model.
module tb_elevator_ctrl;

  localparam int NF = 4;
  localparam int FT = 4;
  localparam int DT = 3;

  localparam int MIdle = 0;
  localparam int MUp   = 1;
  localparam int MDown = 2;
  localparam int MDoor = 3;

  logic          clk;
  logic          rst;
  logic [NF-1:0] req;
  logic [1:0]    floor;
  logic          moving_up, moving_down, door_open, arrive;
  logic [NF-1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  elevator_ctrl #(
    .NUM_FLOORS (NF),
    .FLOOR_TICKS(FT),
    .DOOR_TICKS (DT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .floor      (floor),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .door_open  (door_open),
    .pending    (pending),
    .arrive     (arrive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: car position, what it is doing, a per-floor call list and a timer.
  int          m_floor, m_mode, m_t;
  bit          m_dir_up, m_arr;
  bit [NF-1:0] m_pend;

  task automatic model_reset();
    m_floor = 0; m_mode = MIdle; m_t = 0; m_dir_up = 1'b1; m_arr = 1'b0; m_pend = '0;
  endtask

  task automatic model_step(input logic [NF-1:0] r);
    bit [NF-1:0] calls;
    bit ab, be, he;
    calls = m_pend | r;
    ab = 1'b0; be = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (i > m_floor && calls[i]) ab = 1'b1;
      if (i < m_floor && calls[i]) be = 1'b1;
    end
    he = calls[m_floor];
    m_arr = 1'b0;
    case (m_mode)
      MIdle: begin
        if (he) begin
          calls[m_floor] = 1'b0; m_mode = MDoor; m_t = 0; m_arr = 1'b1;
        end else if (ab && be) begin
          m_mode = m_dir_up ? MUp : MDown; m_t = 0;
        end else if (ab) begin
          m_mode = MUp; m_dir_up = 1'b1; m_t = 0;
        end else if (be) begin
          m_mode = MDown; m_dir_up = 1'b0; m_t = 0;
        end
      end
      MUp, MDown: begin
        if (m_t == FT - 1) begin
          m_floor = (m_mode == MUp) ? m_floor + 1 : m_floor - 1;
          m_t = 0;
          if (calls[m_floor]) begin
            calls[m_floor] = 1'b0; m_mode = MDoor; m_arr = 1'b1;
          end
        end else begin
          m_t++;
        end
      end
      default: begin
        calls[m_floor] = 1'b0;
        if (he) m_t = 0;
        else if (m_t == DT - 1) begin
          m_t = 0;
          if (m_dir_up && ab) m_mode = MUp;
          else if (!m_dir_up && be) m_mode = MDown;
          else if (ab) begin m_mode = MUp; m_dir_up = 1'b1; end
          else if (be) begin m_mode = MDown; m_dir_up = 1'b0; end
          else m_mode = MIdle;
        end else m_t++;
      end
    endcase
    m_pend = calls;
  endtask

  function automatic logic [9:0] model_vec();
    return {2'(m_floor), m_mode == MUp, m_mode == MDown, m_mode == MDoor, m_arr, m_pend};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {floor, moving_up, moving_down, door_open, arrive, pending};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic cmp_model(input string name);
    check(name, int'(dut_vec()), int'(model_vec()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(req);
    #1;
    cmp_model("lockstep");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    cmp_model("reset_state");
    rst = 1'b0;
  endtask

  task automatic press(input logic [NF-1:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  // Ticks until an arrive pulse; returns the floor, or -1 when the budget runs out.
  task automatic wait_arrive(input int budget, output int fl);
    fl = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (arrive === 1'b1) begin
        fl = int'(floor);
        return;
      end
    end
  endtask

  typedef struct packed {
    logic          rst;
    logic [NF-1:0] req;
    logic [1:0]    floor;
    logic          up;
    logic          down;
    logic          door;
    logic          arr;
    logic [NF-1:0] pend;
  } vec_t;

  vec_t vecs[$];
  int   fl;

  initial begin
    rst = 1'b1;
    req = '0;
    model_reset();

    // Call to floor 2 from idle at 0, then a call at the current floor from idle.
    vecs.push_back('{1'b1, 4'b0100, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100});
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100});
    vecs.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000});
    for (int i = 0; i < 2; i++) vecs.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000});
    for (int i = 0; i < 2; i++) vecs.push_back('{1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000});
    vecs.push_back('{1'b1, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000});
    for (int i = 0; i < 2; i++) vecs.push_back('{1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000});
    for (int i = 0; i < 2; i++) vecs.push_back('{1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000});

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      req = vecs[i].req;
      tick();
      check($sformatf("vec%0d", i), int'(dut_vec()),
            int'({vecs[i].floor, vecs[i].up, vecs[i].down, vecs[i].door, vecs[i].arr,
                  vecs[i].pend}));
    end
    req = '0;

    // Calls for 2 and 0 placed while travelling 1 -> 3: serve 2, 3, then reverse to 0.
    do_reset();
    press(4'b0010);
    wait_arrive(20, fl);
    check("t3_first_stop", fl, 1);
    repeat (DT) tick();
    press(4'b1000);
    check("t3_moving_up", int'(moving_up), 1);
    tick();
    press(4'b0101);
    wait_arrive(20, fl);
    check("t3_stop_2", fl, 2);
    wait_arrive(20, fl);
    check("t3_stop_3", fl, 3);
    repeat (DT) tick();
    check("t3_reverse", int'(moving_down), 1);
    wait_arrive(30, fl);
    check("t3_stop_0", fl, 0);
    repeat (DT) tick();
    check("t3_pending_end", int'(pending), 0);
    check("t3_idle", int'({moving_up, moving_down, door_open}), 0);

    // Re-press at the open floor on the last dwell cycle restarts the dwell.
    do_reset();
    press(4'b0100);
    wait_arrive(20, fl);
    check("t4_arrive", fl, 2);
    repeat (DT - 1) tick();
    req = 4'b0100;
    tick();
    req = '0;
    check("t4_door_hold0", int'({door_open, pending[2]}), 2);
    tick();
    check("t4_door_hold1", int'({door_open, pending[2]}), 2);
    tick();
    check("t4_door_hold2", int'({door_open, pending[2]}), 2);
    tick();
    check("t4_door_closed", int'(door_open), 0);

    // Idle at 1 heading down with calls both ways: down first, then up.
    do_reset();
    press(4'b0100);
    wait_arrive(20, fl);
    repeat (DT) tick();
    press(4'b0010);
    check("t5_go_down", int'(moving_down), 1);
    wait_arrive(20, fl);
    check("t5_at_1", fl, 1);
    repeat (DT) tick();
    press(4'b1001);
    check("t5_keep_down", int'(moving_down), 1);
    wait_arrive(20, fl);
    check("t5_stop_0", fl, 0);
    repeat (DT) tick();
    check("t5_reverse_up", int'(moving_up), 1);
    wait_arrive(30, fl);
    check("t5_stop_3", fl, 3);

    // Asynchronous reset between floors 1 and 2.
    do_reset();
    press(4'b0100);
    repeat (5) tick();
    check("t6_mid_travel", int'({floor, moving_up}), 3);
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_floor", int'(floor), 0);
    check("t6_async_outs", int'({moving_up, moving_down, door_open, arrive, pending}), 0);
    rst = 1'b0;
    press(4'b0010);
    wait_arrive(20, fl);
    check("t6_after_reset", fl, 1);
    repeat (DT) tick();
    check("t6_pending_end", int'(pending), 0);

    // Random calls with occasional asynchronous resets, checked cycle by cycle against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      tick();
      check("door_pending_clear", int'(door_open & pending[floor]), 0);
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
